// File: rtl/reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// Optional REG_ARB_ABORT_EN: a grant is dropped if its request falls during the hold window.
module reg_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned HOLD = 2,
  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           res,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic [PW-1:0]  owner,
  output logic           busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;
  logic [PW-1:0] owner_q, owner_d;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] nxt_ptr;
  int unsigned   rr_j;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_j      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      rr_j = (32'(ptr_q) + k) % N;
      if (!sel_found && req[rr_j]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(rr_j);
      end
    end
  end

  assign nxt_ptr = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          owner_d = sel_idx;
          gnt_d   = N'(1) << sel_idx;
          cnt_d   = 8'(HOLD - 1);
          state_d = StGrant;
        end
      end
      StGrant: begin
`ifdef REG_ARB_ABORT_EN
        if (!req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = StIdle;
        end else
`endif
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // din is sampled at this final grant edge, not at grant time.
          q_d     = din[owner_q*W +: W];
          gnt_d   = '0;
          ack_d   = N'(1) << owner_q;
          ptr_d   = nxt_ptr;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      owner_q <= owner_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_reg_arbiter.sv
// Bench for reg_arbiter: directed scenarios plus random traffic against a
// transaction-timeline reference model (age = cycles since the grant edge).
module tb_reg_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned HOLD = 2;
  localparam int unsigned PW   = 2;

  logic           clk = 1'b0;
  logic           res = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [PW-1:0]  owner;
  logic           busy;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int          m_age   = 0;
  int          m_owner = 0;
  int          m_ptr   = 0;
  logic [W-1:0] m_q    = '0;

  reg_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clk(clk), .res(res), .req(req), .din(din),
    .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_gnt();
    return (m_age >= 1 && m_age <= int'(HOLD)) ? N'(1) << m_owner : '0;
  endfunction

  function automatic logic [N-1:0] exp_ack();
    return (m_age == int'(HOLD) + 1) ? N'(1) << m_owner : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    bit found;
    if (res) begin
      m_age = 0; m_owner = 0; m_ptr = 0; m_q = '0;
    end else if (m_age == 0) begin
      found = 0;
      for (int k = 0; k < int'(N); k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && req[idx]) begin
          found = 1; m_owner = idx; m_age = 1;
        end
      end
    end else if (m_age <= int'(HOLD)) begin
`ifdef REG_ARB_ABORT_EN
      if (!req[m_owner]) begin
        m_age = 0; m_ptr = (m_owner + 1) % N;
      end else
`endif
      if (m_age == int'(HOLD)) begin
        m_q   = din[m_owner*W +: W];
        m_ptr = (m_owner + 1) % N;
        m_age = HOLD + 1;
      end else begin
        m_age++;
      end
    end else begin
      m_age = 0;
    end
  endtask

  task automatic cmp_model();
    chk("m_gnt",   32'(gnt),   32'(exp_gnt()));
    chk("m_ack",   32'(ack),   32'(exp_ack()));
    chk("m_q",     32'(q),     32'(m_q));
    chk("m_owner", 32'(owner), 32'(m_owner));
    chk("m_busy",  32'(busy),  32'(m_age != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    din[i*W +: W] = v;
  endtask

  initial begin
    logic [N-1:0] pending;

    // Reset then idle
    res = 1'b1; step(); res = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_ack", 32'(ack), 32'h0);
      chk("idle_q", 32'(q), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_owner", 32'(owner), 32'h0);
    end

    // Single request on requester 2
    req = 4'b0100; set_slice(2, 8'hA5);
    step(); chk("r2_gnt1", 32'(gnt), 32'h4); chk("r2_owner", 32'(owner), 32'd2);
    step(); chk("r2_gnt2", 32'(gnt), 32'h4);
    step(); chk("r2_ack", 32'(ack), 32'h4); chk("r2_q", 32'(q), 32'hA5);
    chk("r2_gnt_off", 32'(gnt), 32'h0);
    step(); chk("r2_ack_off", 32'(ack), 32'h0); chk("r2_gnt_again", 32'(gnt), 32'h0);
    step(); chk("r2_regrant", 32'(gnt), 32'h4);
    req = '0; step(); step(); step();

    // All requesting: rotation 0,1,2,3 then wrap to 0
    res = 1'b1; step(); res = 1'b0;
    for (int i = 0; i < int'(N); i++) set_slice(i, 8'(8'h10 + 8'h11 * i));
    req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      step(); chk("rr_gnt", 32'(gnt), 32'(1 << t));
      step();
      step(); chk("rr_ack", 32'(ack), 32'(1 << t)); chk("rr_q", 32'(q), 32'(8'h10 + 8'h11 * t));
      if (t == 3) req = 4'b1001;
      step(); chk("rr_done", 32'(busy), 32'h0);
    end
    step(); chk("wrap_gnt", 32'(gnt), 32'h1);
    step(); step(); req = '0; step();

    // Reset in the second grant cycle
    req = 4'b0010;
    step(); step(); chk("rst_mid_gnt", 32'(gnt), 32'h2);
    res = 1'b1; step();
    chk("rst_gnt", 32'(gnt), 32'h0); chk("rst_ack", 32'(ack), 32'h0); chk("rst_q", 32'(q), 32'h0);
    res = 1'b0; step(); chk("rst_regrant", 32'(gnt), 32'h2); chk("rst_owner", 32'(owner), 32'd1);
    step(); step(); chk("rst_ack2", 32'(ack), 32'h2); req = '0; step();

    // Request dropped during grant, q preloaded with 0x11
    req = 4'b0001; set_slice(0, 8'h11);
    step(); step(); step(); chk("pre_q", 32'(q), 32'h11); req = '0; step();
    req = 4'b0010; set_slice(1, 8'h3C);
    step(); chk("drop_gnt", 32'(gnt), 32'h2);
    req = '0; step();
`ifdef REG_ARB_ABORT_EN
    chk("abort_gnt", 32'(gnt), 32'h0); chk("abort_busy", 32'(busy), 32'h0);
    step(); chk("abort_ack", 32'(ack), 32'h0); chk("abort_q", 32'(q), 32'h11);
`else
    chk("keep_gnt", 32'(gnt), 32'h2);
    step(); chk("keep_ack", 32'(ack), 32'h2); chk("keep_q", 32'(q), 32'h3C);
    step();
`endif

    // Data changing between grant cycles: last value is captured
    req = 4'b0001; set_slice(0, 8'h01);
    step(); set_slice(0, 8'h02);
    step(); step(); chk("late_q", 32'(q), 32'h02); chk("late_ack", 32'(ack), 32'h1);
    req = '0; step();

    // Random traffic: requests held until acknowledged
    pending = '0;
    for (int c = 0; c < 600; c++) begin
      pending &= ~exp_ack();
      if ($urandom_range(2) == 0) pending |= N'($urandom);
      if ($urandom_range(15) == 0) pending &= ~(N'(1) << $urandom_range(N - 1));
      res = ($urandom_range(63) == 0);
      din = {$urandom, $urandom};
      req = pending;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
